fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq_pkg.sv | 21 ++
 rtl/fir_mac_seq_if.sv | 32 +++
 rtl/fir_mac_seq_coef_rf.sv | 38 +++
 rtl/fir_mac_seq.sv | 141 ++++++++++++++
 tb/tb_fir_mac_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mac_seq_pkg.sv
// Shared FIR package (fir_pkg): FSM state encoding, default datapath sizes
// and the accumulator-width helper used by every FIR block.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  localparam int FIR_WIDTH  = 3;
  localparam int FIR_DEPTH  = 40;
  localparam int FIR_CWIDTH = 16;
  localparam int FIR_OWIDTH = 16;

  // Sized so a full-scale sum over all taps can never overflow.
  function automatic int firAccWidth(input int w, input int cw, input int depth);
    return w + cw + $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Control/data bundle between the sample FSM (master) and fir_mac_seq (slave).
interface fir_mac_seq_if
  import fir_pkg::*;
#(
  parameter int WIDTH  = FIR_WIDTH,
  parameter int DEPTH  = FIR_DEPTH,
  parameter int CWIDTH = FIR_CWIDTH,
  parameter int OWIDTH = FIR_OWIDTH
) ();

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    iEnMac;
  logic [WIDTH*DEPTH-1:0]  iTaps;
  logic                    iCoefWr;
  logic [AW-1:0]           iCoefAddr;
  logic [CWIDTH-1:0]       iCoefData;
  logic                    oBusy;
  logic                    oValid;
  logic [OWIDTH-1:0]       oFirOut;

  modport master (
    output iEnMac, iTaps, iCoefWr, iCoefAddr, iCoefData,
    input  oBusy, oValid, oFirOut
  );

  modport slave (
    input  iEnMac, iTaps, iCoefWr, iCoefAddr, iCoefData,
    output oBusy, oValid, oFirOut
  );

endinterface

// File: rtl/fir_mac_seq_coef_rf.sv
// fir_coef_rf: coefficient register file; writes land only while idle and
// only for in-range addresses.
module fir_coef_rf
  import fir_pkg::*;
#(
  parameter int DEPTH  = FIR_DEPTH,
  parameter int CWIDTH = FIR_CWIDTH,
  parameter int AW     = $clog2(FIR_DEPTH)
) (
  input  logic                    iClk12M,
  input  logic                    iRsn,
  input  logic                    wrEn_i,
  input  logic                    busy_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [CWIDTH-1:0]       data_i,
  output logic [DEPTH*CWIDTH-1:0] coefFlat_o
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [CWIDTH-1:0] coef_q [DEPTH];
  logic              wrOk;

  assign wrOk = wrEn_i && !busy_i && ({1'b0, addr_i} < DEPTH_C);

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      coef_q <= '{default: '0};
    end else if (wrOk) begin
      coef_q[addr_i] <= data_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gFlat
    assign coefFlat_o[i*CWIDTH +: CWIDTH] = coef_q[i];
  end

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR MAC, LANES products per cycle.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int WIDTH  = FIR_WIDTH,
  parameter int DEPTH  = FIR_DEPTH,
  parameter int CWIDTH = FIR_CWIDTH,
  parameter int LANES  = 4,
  parameter int OWIDTH = FIR_OWIDTH,
  parameter int SHIFT  = 0
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  fir_mac_seq_if.slave  bus
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GROUPS = DEPTH / LANES;
  localparam int CNTW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int ACCW   = firAccWidth(WIDTH, CWIDTH, DEPTH);
  localparam int PW     = WIDTH + CWIDTH;
  localparam int SATLO  = (OWIDTH < ACCW) ? OWIDTH - 1 : ACCW - 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(GROUPS - 1);

  fir_state_e               state_q;
  logic [CNTW-1:0]          cnt_q;
  logic signed [ACCW-1:0]   acc_q;
  logic [WIDTH*DEPTH-1:0]   snap_q;
  logic                     busy_q;
  logic                     valid_q;
  logic [OWIDTH-1:0]        firOut_q;
  logic [OWIDTH-1:0]        firOut_d;

  logic [DEPTH*CWIDTH-1:0]  coefFlat;
  logic [LANES*WIDTH-1:0]   tapGrp  [GROUPS];
  logic [LANES*CWIDTH-1:0]  coefGrp [GROUPS];
  logic signed [PW-1:0]     prodArr [LANES];
  logic signed [ACCW-1:0]   groupSum;
  logic signed [ACCW-1:0]   accShift;
  logic                     start;

  fir_coef_rf #(
    .DEPTH (DEPTH),
    .CWIDTH(CWIDTH),
    .AW    (AW)
  ) uCoefRf (
    .iClk12M   (iClk12M),
    .iRsn      (iRsn),
    .wrEn_i    (bus.iCoefWr),
    .busy_i    (busy_q),
    .addr_i    (bus.iCoefAddr),
    .data_i    (bus.iCoefData),
    .coefFlat_o(coefFlat)
  );

  for (genvar g = 0; g < GROUPS; g++) begin : gGrp
    assign tapGrp[g]  = snap_q[g*LANES*WIDTH +: LANES*WIDTH];
    assign coefGrp[g] = coefFlat[g*LANES*CWIDTH +: LANES*CWIDTH];
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic signed [WIDTH-1:0]  tapS;
    logic signed [CWIDTH-1:0] coefS;
    assign tapS       = tapGrp[cnt_q][l*WIDTH +: WIDTH];
    assign coefS      = coefGrp[cnt_q][l*CWIDTH +: CWIDTH];
    assign prodArr[l] = PW'(tapS) * PW'(coefS);
  end

  always_comb begin
    groupSum = '0;
    for (int l = 0; l < LANES; l++) begin
      groupSum = groupSum + ACCW'(prodArr[l]);
    end
  end

  assign accShift = acc_q >>> SHIFT;

  // Out of range means the bits above the output sign bit disagree with it.
  always_comb begin
    firOut_d = OWIDTH'(accShift);
`ifdef FIR_MAC_SAT_EN
    if (OWIDTH < ACCW) begin
      if (accShift[ACCW-1] && !(&accShift[ACCW-1:SATLO])) begin
        firOut_d = {1'b1, {(OWIDTH-1){1'b0}}};
      end else if (!accShift[ACCW-1] && (|accShift[ACCW-1:SATLO])) begin
        firOut_d = {1'b0, {(OWIDTH-1){1'b1}}};
      end
    end
`endif
  end

  assign start = bus.iEnMac && !busy_q;

  // busy_q stays high through the IDLE cycle after DONE, which blocks a
  // restart until the strobe has retired.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      snap_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      firOut_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            snap_q  <= bus.iTaps;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_q + groupSum;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          firOut_q <= firOut_d;
          valid_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBusy   = busy_q;
  assign bus.oValid  = valid_q;
  assign bus.oFirOut = firOut_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: vector table, multi-cycle corner
// sequences and randomized runs against an arithmetic reference model.
module tb_fir_mac_seq;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 40;
  localparam int CWIDTH = 16;
  localparam int LANES  = 4;
  localparam int OWIDTH = 16;
  localparam int SHIFT  = 0;
  localparam int AW     = 6;
  localparam int NVEC   = 7;

`ifdef FIR_MAC_SAT_EN
  localparam logic [15:0] EXP_NEG_BIG  = 16'h8000;
  localparam logic [15:0] EXP_NEG_EVEN = 16'h8000;
  localparam logic [15:0] EXP_POS_BIG  = 16'h7FFF;
`else
  localparam logic [15:0] EXP_NEG_BIG  = 16'h00A0;
  localparam logic [15:0] EXP_NEG_EVEN = 16'h0000;
  localparam logic [15:0] EXP_POS_BIG  = 16'h0000;
`endif

  typedef struct {
    string       name;
    int          tapFill;
    int          impIdx;
    int          impVal;
    int          coefAll;
    int          coefAddr;
    int          coefVal;
    logic [15:0] expOut;
  } vec_t;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;
  int   tapModel  [DEPTH];
  int   coefModel [DEPTH];
  vec_t vecs      [NVEC];

  fir_mac_seq_if #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CWIDTH(CWIDTH),
    .OWIDTH(OWIDTH)
  ) bus ();

  fir_mac_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CWIDTH(CWIDTH),
    .LANES (LANES),
    .OWIDTH(OWIDTH),
    .SHIFT (SHIFT)
  ) dut (
    .iClk12M(clk),
    .iRsn   (rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sum of products from plain integers, then shift and output reduction.
  function automatic logic [OWIDTH-1:0] refModel();
    longint acc;
    longint maxV;
    acc  = 0;
    maxV = (longint'(1) <<< (OWIDTH - 1)) - 1;
    for (int i = 0; i < DEPTH; i++) acc += longint'(tapModel[i]) * longint'(coefModel[i]);
    acc = acc >>> SHIFT;
`ifdef FIR_MAC_SAT_EN
    if (acc > maxV) acc = maxV;
    else if (acc < -maxV - 1) acc = -maxV - 1;
`endif
    return OWIDTH'(acc);
  endfunction

  task automatic driveTaps();
    logic [WIDTH*DEPTH-1:0] v;
    v = '0;
    for (int i = DEPTH - 1; i >= 0; i--) v = {v[WIDTH*DEPTH-WIDTH-1:0], WIDTH'(tapModel[i])};
    bus.iTaps = v;
  endtask

  task automatic writeCoef(input int addr, input int data);
    bus.iCoefWr   = 1'b1;
    bus.iCoefAddr = AW'(addr);
    bus.iCoefData = CWIDTH'(data);
    @(negedge clk);
    bus.iCoefWr = 1'b0;
    if (addr < DEPTH) coefModel[addr] = data;
  endtask

  // Starts a MAC from a negedge and watches 15 further cycles.
  // mode 0 plain, 1 disturbances while busy, 2 reset mid-run, 3 write+start.
  task automatic runMac(input string name, input int mode, input logic [15:0] expOut);
    int   validAt;
    int   validCount;
    logic busyAt11;
    logic busyAt12;
    validAt    = -1;
    validCount = 0;
    busyAt11   = 1'b0;
    busyAt12   = 1'b1;
    bus.iEnMac = 1'b1;
    if (mode == 3) begin
      bus.iCoefWr   = 1'b1;
      bus.iCoefAddr = '0;
      bus.iCoefData = 16'd1234;
    end
    @(negedge clk);
    bus.iEnMac  = 1'b0;
    bus.iCoefWr = 1'b0;
    checkOutput({name, "/busyStart"}, 32'(bus.oBusy), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      if (mode == 1) begin
        if (k == 1) bus.iTaps = {DEPTH{3'b100}};
        if (k == 3) bus.iEnMac = 1'b1;
        if (k == 4) bus.iEnMac = 1'b0;
        if (k == 5) begin
          bus.iCoefWr   = 1'b1;
          bus.iCoefAddr = '0;
          bus.iCoefData = 16'h7FF0;
        end
        if (k == 6) bus.iCoefWr = 1'b0;
      end
      if (mode == 2) begin
        if (k == 6) rstN = 1'b0;
        if (k == 7) rstN = 1'b1;
      end
      @(negedge clk);
      if (bus.oValid) begin
        validCount++;
        if (validCount == 1) begin
          validAt = k;
          checkOutput({name, "/out"}, 32'(bus.oFirOut), 32'(expOut));
        end
      end
      if (k == 11) busyAt11 = bus.oBusy;
      if (k == 12) busyAt12 = bus.oBusy;
    end
    if (mode == 2) begin
      for (int i = 0; i < DEPTH; i++) coefModel[i] = 0;
      checkOutput({name, "/validCount"}, 32'(validCount), 32'd0);
      checkOutput({name, "/outCleared"}, 32'(bus.oFirOut), 32'd0);
      checkOutput({name, "/busyCleared"}, 32'(bus.oBusy), 32'd0);
    end else begin
      checkOutput({name, "/validAt"}, 32'(validAt), 32'd11);
      checkOutput({name, "/validCount"}, 32'(validCount), 32'd1);
      checkOutput({name, "/busyAt11"}, 32'(busyAt11), 32'd1);
      checkOutput({name, "/busyAt12"}, 32'(busyAt12), 32'd0);
      checkOutput({name, "/outHeld"}, 32'(bus.oFirOut), 32'(expOut));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.coefAll != 0) begin
      for (int i = 0; i < DEPTH; i++) writeCoef(i, v.coefVal);
    end else begin
      writeCoef(v.coefAddr, v.coefVal);
    end
    for (int i = 0; i < DEPTH; i++) tapModel[i] = v.tapFill;
    if (v.impIdx >= 0) tapModel[v.impIdx] = v.impVal;
    driveTaps();
    runMac(v.name, 0, v.expOut);
  endtask

  initial begin
    logic [15:0] expRnd;
    checks        = 0;
    errors        = 0;
    rstN          = 1'b0;
    bus.iEnMac    = 1'b0;
    bus.iTaps     = '0;
    bus.iCoefWr   = 1'b0;
    bus.iCoefAddr = '0;
    bus.iCoefData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tapModel[i]  = 0;
      coefModel[i] = 0;
    end

    vecs[0] = '{"allOnes",       1, -1,  0, 1,  0,      1, 16'h0028};
    vecs[1] = '{"impulseTap8",   0,  7,  1, 0,  7,   -300, 16'hFED4};
    vecs[2] = '{"negBig",       -4, -1,  0, 1,  0,  32767, EXP_NEG_BIG};
    vecs[3] = '{"maxTapMinCoef", 3, -1,  0, 1,  0, -32768, EXP_NEG_EVEN};
    vecs[4] = '{"posBig",       -4, -1,  0, 1,  0, -32768, EXP_POS_BIG};
    vecs[5] = '{"lastTap",       0, 39, -4, 0, 39,      7, 16'hFFE4};
    vecs[6] = '{"firstTap",      0,  0,  3, 0,  0,     -5, 16'hFFF1};

    repeat (3) @(negedge clk);
    checkOutput("reset/busy", 32'(bus.oBusy), 32'd0);
    checkOutput("reset/valid", 32'(bus.oValid), 32'd0);
    checkOutput("reset/out", 32'(bus.oFirOut), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NVEC; v++) applyStimulus(vecs[v]);

    for (int i = 0; i < DEPTH; i++) tapModel[i] = 0;
    tapModel[0] = 1;
    driveTaps();
    coefModel[0] = 1234;
    runMac("simulWrite", 3, 16'h04D2);

    for (int i = 0; i < DEPTH; i++) tapModel[i] = int'($urandom_range(0, 7)) - 4;
    driveTaps();
    runMac("disturb", 1, refModel());
    for (int i = 0; i < DEPTH; i++) tapModel[i] = 0;
    tapModel[0] = 1;
    driveTaps();
    runMac("coefKept", 0, 16'h04D2);

    for (int i = 0; i < DEPTH; i++) tapModel[i] = 1;
    driveTaps();
    runMac("midReset", 2, 16'h0000);
    runMac("afterReset", 0, 16'h0000);

    for (int i = 0; i < DEPTH; i++) writeCoef(i, int'($urandom_range(0, 65535)) - 32768);
    for (int j = 0; j < 5; j++) writeCoef(int'($urandom_range(DEPTH, 63)), int'($urandom_range(0, 65535)) - 32768);
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < DEPTH; i++) tapModel[i] = int'($urandom_range(0, 7)) - 4;
      driveTaps();
      expRnd = refModel();
      runMac($sformatf("rand%0d", s), 0, expRnd);
      repeat (4) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
